alu_cmd_seq: RTL and testbench

ALU_CMD_SEQ -- requirements
Module: alu_cmd_seq

---
 rtl/alu_cmd_seq.sv | 122 ++++++++++++
 tb/tb_alu_cmd_seq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_seq.sv
// alu_cmd_seq: receives CMD/A/B/FUN byte frames, drives one ALU operation and forwards the result byte to the transmitter.
// Optional build macro ALU_DIV0_CHK_EN: reject divide (code 3) frames whose B operand is zero.
module alu_cmd_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int FUN_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] CMD_BYTE = 8'hCC,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    output logic [DATA_WIDTH-1:0] ALU_A,
    output logic [DATA_WIDTH-1:0] ALU_B,
    output logic [FUN_WIDTH-1:0]  ALU_FUN,
    output logic                  ALU_EN,
    input  logic [DATA_WIDTH-1:0] ALU_OUT,
    input  logic                  ALU_OUT_VLD,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD,
    input  logic                  TX_BUSY,
    output logic                  BUSY,
    output logic                  ERR
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYC);
    localparam logic [CW-1:0] TLAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {IDLE, GET_A, GET_B, GET_FUN, EXEC, WAIT_RES, SEND} state_t;

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   alu_a_q, alu_b_q, tx_data_q;
    logic [FUN_WIDTH-1:0]    alu_fun_q;
    logic                    alu_en_q, tx_vld_q, err_q;
    logic [CW-1:0]           cnt_q;
    logic                    fun_ok, div0;

    // a code is legal only when the whole byte is at most 0x0E (upper bits zero)
    assign fun_ok = RX_P_DATA <= DATA_WIDTH'(14);
`ifdef ALU_DIV0_CHK_EN
    assign div0 = (RX_P_DATA == DATA_WIDTH'(3)) && (alu_b_q == '0);
`else
    assign div0 = 1'b0;
`endif

    // frame sequencer: byte collection with inter-byte timeout, ALU handshake and transmit hand-off
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_fun_q <= '0;
            alu_en_q  <= 1'b0;
            tx_data_q <= '0;
            tx_vld_q  <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            alu_en_q <= 1'b0;
            tx_vld_q <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (RX_D_VLD && RX_P_DATA == CMD_BYTE) begin
                        state_q <= GET_A;
                        cnt_q   <= '0;
                    end else if (RX_D_VLD) begin
                        err_q <= 1'b1;
                    end
                end
                GET_A, GET_B, GET_FUN: begin
                    if (RX_D_VLD) begin
                        cnt_q <= '0;
                        if (state_q == GET_A) begin
                            alu_a_q <= RX_P_DATA;
                            state_q <= GET_B;
                        end else if (state_q == GET_B) begin
                            alu_b_q <= RX_P_DATA;
                            state_q <= GET_FUN;
                        end else if (fun_ok && !div0) begin
                            alu_fun_q <= RX_P_DATA[FUN_WIDTH-1:0];
                            alu_en_q  <= 1'b1;
                            state_q   <= EXEC;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else if (cnt_q >= TLAST) begin
                        err_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= (cnt_q == TMAX) ? cnt_q : cnt_q + 1'b1;
                    end
                end
                EXEC: state_q <= WAIT_RES;
                WAIT_RES: begin
                    if (ALU_OUT_VLD) begin
                        tx_data_q <= ALU_OUT;
                        state_q   <= SEND;
                    end
                end
                SEND: begin
                    if (!TX_BUSY) begin
                        tx_vld_q <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ALU_A     = alu_a_q;
    assign ALU_B     = alu_b_q;
    assign ALU_FUN   = alu_fun_q;
    assign ALU_EN    = alu_en_q;
    assign TX_P_DATA = tx_data_q;
    assign TX_D_VLD  = tx_vld_q;
    assign ERR       = err_q;
    assign BUSY      = state_q != IDLE;
endmodule

// File: tb/tb_alu_cmd_seq.sv
// tb_alu_cmd_seq: directed and randomized frames; expected ALU/TX/ERR events queued by stimulus, popped by a monitor.
module tb_alu_cmd_seq;
    localparam int T = 255;
    localparam logic [7:0] CMD = 8'hCC;
`ifdef ALU_DIV0_CHK_EN
    localparam bit DIV0 = 1'b1;
`else
    localparam bit DIV0 = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] RX_P_DATA = 8'h00;
    logic       RX_D_VLD = 1'b0;
    logic [7:0] ALU_A, ALU_B, TX_P_DATA;
    logic [3:0] ALU_FUN;
    logic       ALU_EN, TX_D_VLD, BUSY, ERR;
    logic [7:0] ALU_OUT = 8'h00;
    logic       ALU_OUT_VLD = 1'b0;
    logic       TX_BUSY = 1'b0;
    logic       busy_prev = 1'b0;
    int         checks = 0;
    int         passed = 0;

    typedef struct {int kind; logic [7:0] a; logic [7:0] b; logic [7:0] f;} ev_t;
    ev_t exp_q[$];

    alu_cmd_seq dut (
        .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
        .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD), .TX_P_DATA(TX_P_DATA),
        .TX_D_VLD(TX_D_VLD), .TX_BUSY(TX_BUSY), .BUSY(BUSY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
        case (f)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a * b;
            4'h3: return (b == 8'h00) ? 8'h00 : a / b;
            4'h4: return a & b;
            4'h5: return a | b;
            4'h6: return ~(a & b);
            4'h7: return ~(a | b);
            4'h8: return a ^ b;
            4'h9: return ~(a ^ b);
            4'hA: return {7'd0, a == b};
            4'hB: return {7'd0, a > b};
            4'hC: return {7'd0, a < b};
            4'hD: return a >> 1;
            4'hE: return a << 1;
            default: return 8'h00;
        endcase
    endfunction

    // external ALU: registered result, valid the cycle after enable
    always @(posedge CLK) begin
        ALU_OUT_VLD <= ALU_EN && !RST;
        ALU_OUT <= alu_ref(ALU_A, ALU_B, ALU_FUN);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    task automatic take(input int kind, input logic [7:0] a, input logic [7:0] b, input logic [7:0] f);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_event: got kind %0d, expected none", kind);
            return;
        end
        e = exp_q.pop_front();
        check("event_kind", kind, e.kind);
        if (kind == e.kind && kind != 2) begin
            check(kind == 0 ? "alu_a" : "tx_data", a, e.a);
            if (kind == 0) begin
                check("alu_b", b, e.b);
                check("alu_fun", f, e.f);
            end
        end
    endtask

    // monitor: every ALU_EN, TX_D_VLD and ERR pulse must match the head of the expectation queue
    always @(negedge CLK) begin
        if (TX_D_VLD) check("tx_while_busy", busy_prev, 0);
        if (ALU_EN) take(0, ALU_A, ALU_B, {4'd0, ALU_FUN});
        if (TX_D_VLD) take(1, TX_P_DATA, 8'h00, 8'h00);
        if (ERR) take(2, 8'h00, 8'h00, 8'h00);
        busy_prev = TX_BUSY;
    end

    task automatic push(input int kind, input logic [7:0] a, input logic [7:0] b, input logic [7:0] f);
        ev_t e;
        e.kind = kind; e.a = a; e.b = b; e.f = f;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        if (n > 0) tick(n);
    endtask

    task automatic send(input logic [7:0] d);
        RX_P_DATA = d;
        RX_D_VLD = 1'b1;
        tick(1);
        RX_D_VLD = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (BUSY && n < 2000) begin
            tick(1);
            n++;
        end
        check("busy_drains", BUSY, 0);
        tick(2);
    endtask

    task automatic check_reset_vals();
        check("rst_alu_a", ALU_A, 0);
        check("rst_alu_b", ALU_B, 0);
        check("rst_alu_fun", ALU_FUN, 0);
        check("rst_alu_en", ALU_EN, 0);
        check("rst_tx_data", TX_P_DATA, 0);
        check("rst_tx_vld", TX_D_VLD, 0);
        check("rst_busy", BUSY, 0);
        check("rst_err", ERR, 0);
    endtask

    // valid-format frame: expected outcome decided from operands and code alone
    task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f,
                         input int gap, input int junk, input int hold);
        bit rej = DIV0 && f == 8'h03 && b == 8'h00;
        send(CMD); idle(gap);
        send(a); idle(gap);
        send(b); idle(gap);
        if (rej) push(2, 0, 0, 0);
        else begin
            push(0, a, b, f);
            push(1, alu_ref(a, b, f[3:0]), 0, 0);
        end
        if (hold > 0) TX_BUSY = 1'b1;
        send(f);
        if (!rej) for (int i = 0; i < junk; i++) send(8'($urandom_range(0, 255)));
        if (hold > 0) begin
            idle(hold);
            TX_BUSY = 1'b0;
        end
        wait_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tick(2);
        check_reset_vals();
        RST = 1'b0;
        tick(1);

        send(CMD); send(8'h05); send(8'h03);
        push(0, 8'h05, 8'h03, 8'h00);
        push(1, 8'h08, 0, 0);
        send(8'h00);
        check("en_after_fun", ALU_EN, 1);
        tick(2);
        check("tx_not_early", TX_D_VLD, 0);
        tick(1);
        check("tx_latency4", TX_D_VLD, 1);
        check("tx_latency4_data", TX_P_DATA, 8'h08);
        wait_idle();

        push(2, 0, 0, 0);
        send(8'h7A);
        check("bad_cmd_not_busy", BUSY, 0);
        tick(2);
        frame(8'h0A, 8'h02, 8'h01, 0, 0, 0);

        push(2, 0, 0, 0);
        send(CMD); send(8'h10);
        idle(T);
        check("timeout_idle", BUSY, 0);
        wait_idle();
        frame(8'h02, 8'h02, 8'h0A, 0, 0, 0);
        frame(8'h33, 8'h11, 8'h01, T - 1, 0, 0);

        frame(8'h04, 8'h00, 8'h03, 0, 0, 0);
        frame(8'h21, 8'h07, 8'h02, 0, 3, 20);

        send(CMD); send(8'h09); send(8'h04);
        push(0, 8'h09, 8'h04, 8'h00);
        send(8'h00);
        tick(1);
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        check_reset_vals();
        tick(30);

        TX_BUSY = 1'b1;
        send(CMD); send(8'h09); send(8'h04);
        push(0, 8'h09, 8'h04, 8'h08);
        send(8'h08);
        tick(5);
        check("in_send_busy", BUSY, 1);
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        TX_BUSY = 1'b0;
        check_reset_vals();
        tick(30);

        push(2, 0, 0, 0);
        send(CMD); send(8'h11); send(8'h22); send(8'h1F);
        wait_idle();

        for (int n = 0; n < 150; n++) begin
            int r = $urandom_range(0, 11);
            logic [7:0] a = 8'($urandom_range(0, 255));
            logic [7:0] b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            if (r == 0) begin
                logic [7:0] x = 8'($urandom_range(0, 255));
                if (x == CMD) x = 8'hCD;
                push(2, 0, 0, 0);
                send(x);
                wait_idle();
            end else if (r == 1) begin
                push(2, 0, 0, 0);
                send(CMD); send(a); send(b);
                send(8'($urandom_range(15, 255)));
                wait_idle();
            end else if (r == 2 && $urandom_range(0, 3) == 0) begin
                push(2, 0, 0, 0);
                send(CMD);
                if ($urandom_range(0, 1) == 1) send(a);
                idle(T);
                wait_idle();
            end else begin
                frame(a, b, 8'($urandom_range(0, 14)), $urandom_range(0, 3), $urandom_range(0, 3),
                      ($urandom_range(0, 1) == 1) ? $urandom_range(1, 10) : 0);
            end
        end

        tick(10);
        check("expect_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
